// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bin_to_bcd_seq_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a requester and the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
);
  import bin_to_bcd_seq_pkg::*;

  logic                    start;
  logic [BIN_W-1:0]        bin;
  logic                    busy;
  logic                    done;
  logic [BCD_W*DIGITS-1:0] bcd;

  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/bin_to_bcd_seq_dd_add3.sv
// Double-dabble digit adjust: digits of 5 or more get +3 before the shift.
module dd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, with optional
// leading-zero blanking for the downstream 7-segment decoders.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W    = 10,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Reset value of bcd is the blanked image of zero.
  function automatic logic [DIGITS-1:0][BCD_W-1:0] zero_img();
    logic [DIGITS-1:0][BCD_W-1:0] r = '0;
    for (int i = 1; i < DIGITS; i++) if (BLANK_LZ != 0) r[i] = BCD_BLANK;
    return r;
  endfunction

  localparam logic [DIGITS-1:0][BCD_W-1:0] BCD_RST = zero_img();

  if (((64'd1 << BIN_W) - 64'd1) >= pow10(DIGITS)) begin : g_range_chk
    $error("bin_to_bcd_seq: 2**BIN_W-1 does not fit in DIGITS BCD digits");
  end

  state_e                       state, state_d;
  logic [CNT_W-1:0]             cnt;
  logic [BIN_W-1:0]             shreg;
  logic [DIGITS-1:0][BCD_W-1:0] scratch, adj, blanked, bcd_q;
  logic [BCD_W*DIGITS-1:0]      adj_flat;
  logic                         done_q, accept, load, lead;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    dd_add3 u_add3 (.d(scratch[g]), .q(adj[g]));
  end
  assign adj_flat = adj;

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE:  if (bus.start) begin
               accept  = 1'b1;
               state_d = SHIFT;
             end
      SHIFT: if (cnt == LAST) state_d = LOAD;
      LOAD:  begin
               load    = 1'b1;
               state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
  end

  // Blank zeros above the first nonzero digit; the units digit always shows.
  always_comb begin
    blanked = scratch;
    lead    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && scratch[i] == '0) begin
        if (BLANK_LZ != 0) blanked[i] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      scratch <= '0;
      bcd_q   <= BCD_RST;
      done_q  <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= load;
      if (accept) begin
        shreg   <= bus.bin;
        scratch <= '0;
        cnt     <= '0;
      end else if (state == SHIFT) begin
        scratch <= {adj_flat[BCD_W*DIGITS-2:0], shreg[BIN_W-1]};
        shreg   <= {shreg[BIN_W-2:0], 1'b0};
        cnt     <= cnt + CNT_W'(1);
      end
      if (load) bcd_q <= blanked;
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
endmodule
